// File: rtl/aes_mode_pkg.sv
// Shared widths, command codes and state encodings for the AES mode sequencer.
package aes_mode_pkg;

  localparam int unsigned WORD_S = 32;
  localparam int unsigned KEY_S  = 128;
  localparam int unsigned BLK_S  = 128;

  localparam logic [WORD_S-1:0] ECB_ENCRYPT_128 = 32'h0000_0001;
  localparam logic [WORD_S-1:0] ECB_DECRYPT_128 = 32'h0000_0002;
  localparam logic [WORD_S-1:0] SET_KEY_128     = 32'h0000_0003;
  localparam logic [WORD_S-1:0] CBC_ENCRYPT_128 = 32'h0000_0004;
  localparam logic [WORD_S-1:0] CBC_DECRYPT_128 = 32'h0000_0005;
  localparam logic [WORD_S-1:0] CTR_128         = 32'h0000_0006;
  localparam logic [WORD_S-1:0] SET_IV          = 32'h0000_0007;

  typedef enum logic [1:0] {ST_IDLE, ST_KEYEXP, ST_CORE, ST_DONE} state_t;
  typedef enum logic [1:0] {MODE_ECB, MODE_CBC_ENC, MODE_CBC_DEC, MODE_CTR} mode_t;
  typedef enum logic [2:0] {IV_HOLD, IV_LOAD_IN, IV_LOAD_CORE, IV_LOAD_SAVED, IV_INC} iv_op_t;

  function automatic int unsigned slot_w_f(input int unsigned n);
    return (n <= 1) ? 1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/aes_mode_if.sv
// Command front-end and block-core port bundle; slave side is the mode sequencer.
interface aes_mode_if import aes_mode_pkg::*; #(parameter int unsigned KEY_SLOTS = 2);

  localparam int unsigned SLOT_W = slot_w_f(KEY_SLOTS);

  logic              en;
  logic [WORD_S-1:0] aes_cmd;
  logic [SLOT_W-1:0] aes_key_slot;
  logic [KEY_S-1:0]  aes_key;
  logic [BLK_S-1:0]  aes_in_blk;
  logic [BLK_S-1:0]  aes_out_blk;
  logic              en_o;
  logic              cmd_err;
  logic              busy;
  logic              core_key_en;
  logic              core_en;
  logic              core_decrypt;
  logic [SLOT_W-1:0] core_slot;
  logic [KEY_S-1:0]  core_key;
  logic [BLK_S-1:0]  core_blk_in;
  logic [BLK_S-1:0]  core_blk_out;
  logic              core_done;

  modport slave (
    input  en, aes_cmd, aes_key_slot, aes_key, aes_in_blk, core_blk_out, core_done,
    output aes_out_blk, en_o, cmd_err, busy, core_key_en, core_en, core_decrypt,
           core_slot, core_key, core_blk_in
  );

  modport master (
    output en, aes_cmd, aes_key_slot, aes_key, aes_in_blk, core_blk_out, core_done,
    input  aes_out_blk, en_o, cmd_err, busy, core_key_en, core_en, core_decrypt,
           core_slot, core_key, core_blk_in
  );

endinterface

// File: rtl/aes_iv_unit.sv
// IV/counter register with CBC chaining loads and a CTR_W-bit wrapping low-field increment.
module aes_iv_unit import aes_mode_pkg::*; #(
  parameter int unsigned CTR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  iv_op_t           op,
  input  logic [BLK_S-1:0] in_blk,
  input  logic [BLK_S-1:0] core_out,
  input  logic [BLK_S-1:0] saved_in,
  output logic [BLK_S-1:0] iv
);

  // Carry out of the counter field is dropped; upper bits never change on increment.
  localparam logic [BLK_S-1:0] CTR_MASK = {BLK_S{1'b1}} >> (BLK_S - CTR_W);

  logic [BLK_S-1:0] iv_d;
  logic [BLK_S-1:0] iv_inc;

  assign iv_inc = iv + BLK_S'(1);

  always_comb begin
    iv_d = iv;
    case (op)
      IV_LOAD_IN:    iv_d = in_blk;
      IV_LOAD_CORE:  iv_d = core_out;
      IV_LOAD_SAVED: iv_d = saved_in;
      IV_INC:        iv_d = (iv & ~CTR_MASK) | (iv_inc & CTR_MASK);
      default:       iv_d = iv;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) iv <= '0;
    else        iv <= iv_d;
  end

endmodule

// File: rtl/aes_mode_top.sv
// Sequences one AES-128 block core through ECB/CBC/CTR with per-slot key valid tracking.
module aes_mode_top import aes_mode_pkg::*; #(
  parameter int unsigned KEY_SLOTS = 2,
  parameter int unsigned CTR_W     = 32
) (
  input  logic     clk,
  input  logic     reset,
  aes_mode_if.slave bus
);

  localparam int unsigned SLOT_W = slot_w_f(KEY_SLOTS);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [KEY_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [BLK_S-1:0]     saved_q, saved_d, out_q, out_d, blk_q, blk_d;
  logic [KEY_S-1:0]     key_q, key_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 en_o_q, en_o_d, err_q, err_d, busy_q, busy_d;
  logic                 key_en_q, key_en_d, core_en_q, core_en_d, dec_q, dec_d;

  iv_op_t               iv_op_c;
  logic [BLK_S-1:0]     iv;
  logic                 slot_ok_c, keyed_c, known_c, data_c, dec_c;
  mode_t                mode_c;
  logic [BLK_S-1:0]     blk_c;

  assign slot_ok_c = 32'(bus.aes_key_slot) < KEY_SLOTS;
  assign keyed_c   = slot_ok_c && slot_valid_q[bus.aes_key_slot];

  // Command decode: data commands pick their mode, direction and core input.
  always_comb begin
    known_c = 1'b1;
    data_c  = 1'b0;
    dec_c   = 1'b0;
    mode_c  = MODE_ECB;
    blk_c   = bus.aes_in_blk;
    case (bus.aes_cmd)
      SET_KEY_128, SET_IV: known_c = 1'b1;
      ECB_ENCRYPT_128:     data_c = 1'b1;
      ECB_DECRYPT_128:     begin data_c = 1'b1; dec_c = 1'b1; end
      CBC_ENCRYPT_128:     begin data_c = 1'b1; mode_c = MODE_CBC_ENC; blk_c = bus.aes_in_blk ^ iv; end
      CBC_DECRYPT_128:     begin data_c = 1'b1; mode_c = MODE_CBC_DEC; dec_c = 1'b1; end
      CTR_128:             begin data_c = 1'b1; mode_c = MODE_CTR; blk_c = iv; end
      default:             known_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    slot_valid_d = slot_valid_q;
    saved_d      = saved_q;
    blk_d        = blk_q;
    key_d        = key_q;
    slot_d       = slot_q;
    dec_d        = dec_q;
    out_d        = '0;
    en_o_d       = 1'b0;
    err_d        = 1'b0;
    key_en_d     = 1'b0;
    core_en_d    = 1'b0;
    iv_op_c      = IV_HOLD;
    case (state_q)
      ST_IDLE: if (bus.en) begin
        if (!known_c || (bus.aes_cmd != SET_IV && !slot_ok_c) || (data_c && !keyed_c)) begin
          err_d = 1'b1;
        end else if (bus.aes_cmd == SET_IV) begin
          iv_op_c = IV_LOAD_IN;
          en_o_d  = 1'b1;
          state_d = ST_DONE;
        end else if (bus.aes_cmd == SET_KEY_128) begin
          key_d    = bus.aes_key;
          slot_d   = bus.aes_key_slot;
          key_en_d = 1'b1;
          slot_valid_d[bus.aes_key_slot] = 1'b0;
          state_d  = ST_KEYEXP;
        end else begin
          mode_d    = mode_c;
          dec_d     = dec_c;
          blk_d     = blk_c;
          saved_d   = bus.aes_in_blk;
          slot_d    = bus.aes_key_slot;
          core_en_d = 1'b1;
          state_d   = ST_CORE;
        end
      end
      ST_KEYEXP: if (bus.core_done) begin
        slot_valid_d[slot_q] = 1'b1;
        en_o_d  = 1'b1;
        state_d = ST_DONE;
      end
      // Result mux and IV chaining land on the same edge so the next block sees the new IV.
      ST_CORE: if (bus.core_done) begin
        en_o_d  = 1'b1;
        state_d = ST_DONE;
        case (mode_q)
          MODE_CBC_ENC: begin out_d = bus.core_blk_out;           iv_op_c = IV_LOAD_CORE;  end
          MODE_CBC_DEC: begin out_d = bus.core_blk_out ^ iv;      iv_op_c = IV_LOAD_SAVED; end
          MODE_CTR:     begin out_d = saved_q ^ bus.core_blk_out; iv_op_c = IV_INC;        end
          default:      out_d = bus.core_blk_out;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ECB;
      slot_valid_q <= '0;
      saved_q      <= '0;
      blk_q        <= '0;
      key_q        <= '0;
      slot_q       <= '0;
      dec_q        <= 1'b0;
      out_q        <= '0;
      en_o_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      key_en_q     <= 1'b0;
      core_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      slot_valid_q <= slot_valid_d;
      saved_q      <= saved_d;
      blk_q        <= blk_d;
      key_q        <= key_d;
      slot_q       <= slot_d;
      dec_q        <= dec_d;
      out_q        <= out_d;
      en_o_q       <= en_o_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      key_en_q     <= key_en_d;
      core_en_q    <= core_en_d;
    end
  end

  aes_iv_unit #(.CTR_W(CTR_W)) u_iv (
    .clk      (clk),
    .reset    (reset),
    .op       (iv_op_c),
    .in_blk   (bus.aes_in_blk),
    .core_out (bus.core_blk_out),
    .saved_in (saved_q),
    .iv       (iv)
  );

  assign bus.aes_out_blk  = out_q;
  assign bus.en_o         = en_o_q;
  assign bus.cmd_err      = err_q;
  assign bus.busy         = busy_q;
  assign bus.core_key_en  = key_en_q;
  assign bus.core_en      = core_en_q;
  assign bus.core_decrypt = dec_q;
  assign bus.core_slot    = slot_q;
  assign bus.core_key     = key_q;
  assign bus.core_blk_in  = blk_q;

endmodule

// File: tb/tb_aes_mode_top.sv
// Directed bench for aes_mode_top with a table-driven stand-in for the AES block core.
module tb_aes_mode_top;
  import aes_mode_pkg::*;

  localparam int unsigned KS = 2;
  localparam int unsigned SW = slot_w_f(KS);
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] TIMEOUT = {4{32'hdeadbeef}};
  // Known AES-128 pairs under K1 (FIPS-197 / SP800-38A); other inputs use a keyed XOR stand-in.
  localparam logic [127:0] TPT [3] = '{PT, 128'h6bc0bce12a459991e134741a7f9e1925,
                                       128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff};
  localparam logic [127:0] TCT [3] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97,
                                       128'h7649abac8119b246cee98e9b12e9197d,
                                       128'hec8cdf7398607cb0f2d21675ea9ea1e4};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_mode_if #(.KEY_SLOTS(KS)) bus ();
  aes_mode_top #(.KEY_SLOTS(KS), .CTR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int core_en_cnt = 0;
  int cnt = 0;
  int pend_slot = 0;
  logic pend_key = 1'b0;
  logic pend_dec = 1'b0;
  logic [127:0] pend_val = '0;
  logic [127:0] last_core_in = '0;
  logic [127:0] mkey [KS];

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] x, input logic dec);
    if (k == K1) begin
      for (int i = 0; i < 3; i++) begin
        if (!dec && x == TPT[i]) return TCT[i];
        if (dec && x == TCT[i]) return TPT[i];
      end
    end
    return x ^ k;
  endfunction

  // Block core model: three-cycle latency, done pulse spans one rising edge.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    bus.core_blk_out = '0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        bus.core_done = 1'b1;
        if (pend_key) mkey[pend_slot] = pend_val;
        else bus.core_blk_out = cipher(mkey[pend_slot], pend_val, pend_dec);
      end
    end
    if (bus.core_key_en) begin
      pend_key = 1'b1; pend_val = bus.core_key; pend_slot = int'(bus.core_slot); cnt = 3;
    end
    if (bus.core_en) begin
      pend_key = 1'b0; pend_val = bus.core_blk_in; pend_dec = bus.core_decrypt;
      pend_slot = int'(bus.core_slot); cnt = 3;
      last_core_in = bus.core_blk_in; core_en_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] cmd, input int slot, input logic [127:0] key,
                       input logic [127:0] blk, output logic err, output logic cen);
    step();
    bus.en = 1'b1; bus.aes_cmd = cmd; bus.aes_key_slot = SW'(slot);
    bus.aes_key = key; bus.aes_in_blk = blk;
    step();
    bus.en = 1'b0;
    err = bus.cmd_err;
    cen = bus.core_en;
  endtask

  task automatic op(input logic [31:0] cmd, input int slot, input logic [127:0] key,
                    input logic [127:0] blk, output logic [127:0] out, output logic cen, output int lat);
    logic err;
    issue(cmd, slot, key, blk, err, cen);
    out = TIMEOUT;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.en_o) begin out = bus.aes_out_blk; lat = i; break; end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({bus.busy, bus.en_o, bus.cmd_err, bus.core_en, bus.core_key_en} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000",
                         {bus.busy, bus.en_o, bus.cmd_err, bus.core_en, bus.core_key_en});
    end
    checks++;
    if (bus.aes_out_blk !== 128'h0 || bus.core_blk_in !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0", bus.aes_out_blk, bus.core_blk_in);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_ecb();
    logic [127:0] out; logic cen; int lat;
    op(SET_KEY_128, 0, K1, '0, out, cen, lat);
    checks++;
    if (out !== 128'h0) begin errors++; $display("FAIL setkey_out got %h want 0", out); end
    op(ECB_ENCRYPT_128, 0, '0, PT, out, cen, lat);
    checks++;
    if (out !== TCT[0]) begin errors++; $display("FAIL ecb_enc got %h want %h", out, TCT[0]); end
    checks++;
    if (cen !== 1'b1 || lat != 4) begin
      errors++; $display("FAIL ecb_timing got cen=%b lat=%0d want cen=1 lat=4", cen, lat);
    end
    op(ECB_DECRYPT_128, 0, '0, TCT[0], out, cen, lat);
    checks++;
    if (out !== PT) begin errors++; $display("FAIL ecb_dec got %h want %h", out, PT); end
    step();
    checks++;
    if (bus.aes_out_blk !== 128'h0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL out_idle got %h busy=%b want 0", bus.aes_out_blk, bus.busy);
    end
  endtask

  task automatic test_cbc();
    logic [127:0] out; logic cen; int lat;
    op(SET_IV, 0, '0, K2, out, cen, lat);
    checks++;
    if (out !== 128'h0) begin errors++; $display("FAIL setiv_out got %h want 0", out); end
    op(CBC_ENCRYPT_128, 0, '0, PT, out, cen, lat);
    checks++;
    if (out !== TCT[1]) begin errors++; $display("FAIL cbc_enc got %h want %h", out, TCT[1]); end
    op(CTR_128, 0, '0, '0, out, cen, lat);
    checks++;
    if (last_core_in !== TCT[1]) begin
      errors++; $display("FAIL cbc_iv_chain got %h want %h", last_core_in, TCT[1]);
    end
    op(SET_IV, 0, '0, K2, out, cen, lat);
    op(CBC_DECRYPT_128, 0, '0, TCT[1], out, cen, lat);
    checks++;
    if (out !== PT) begin errors++; $display("FAIL cbc_dec got %h want %h", out, PT); end
  endtask

  task automatic test_ctr();
    logic [127:0] out; logic cen; int lat;
    op(SET_IV, 0, '0, TPT[2], out, cen, lat);
    op(CTR_128, 0, '0, PT, out, cen, lat);
    checks++;
    if (out !== 128'h874d6191b620e3261bef6864990db6ce) begin
      errors++; $display("FAIL ctr_out got %h want 874d6191b620e3261bef6864990db6ce", out);
    end
    op(CTR_128, 0, '0, '0, out, cen, lat);
    checks++;
    if (last_core_in !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) begin
      errors++; $display("FAIL ctr_inc got %h want f0f1f2f3f4f5f6f7f8f9fafbfcfdff00", last_core_in);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] out; logic cen; int lat;
    logic [127:0] iv_w;
    iv_w = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    op(SET_IV, 0, '0, iv_w, out, cen, lat);
    op(CTR_128, 0, '0, '0, out, cen, lat);
    checks++;
    if (out !== (iv_w ^ K1)) begin errors++; $display("FAIL wrap_out got %h want %h", out, iv_w ^ K1); end
    op(CTR_128, 0, '0, '0, out, cen, lat);
    checks++;
    if (last_core_in !== 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000) begin
      errors++; $display("FAIL wrap_iv got %h want f0f1f2f3f4f5f6f7f8f9fafb00000000", last_core_in);
    end
  endtask

  task automatic test_errors();
    logic [127:0] out; logic cen, err; int lat, n0;
    n0 = core_en_cnt;
    issue(ECB_ENCRYPT_128, 1, '0, PT, err, cen);
    checks++;
    if (err !== 1'b1 || cen !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL unkeyed_slot got err=%b cen=%b busy=%b want 1 0 0", err, cen, bus.busy);
    end
    issue(32'h0000_00ff, 0, '0, PT, err, cen);
    checks++;
    if (err !== 1'b1 || cen !== 1'b0) begin
      errors++; $display("FAIL bad_opcode got err=%b cen=%b want 1 0", err, cen);
    end
    repeat (5) step();
    checks++;
    if (core_en_cnt != n0 || bus.en_o !== 1'b0) begin
      errors++; $display("FAIL reject_quiet got core_en=%0d en_o=%b want %0d 0", core_en_cnt, bus.en_o, n0);
    end
    op(SET_KEY_128, 1, K2, '0, out, cen, lat);
    op(ECB_ENCRYPT_128, 1, '0, PT, out, cen, lat);
    checks++;
    if (out !== (PT ^ K2)) begin errors++; $display("FAIL slot1_enc got %h want %h", out, PT ^ K2); end
    checks++;
    if (out === TCT[0]) begin errors++; $display("FAIL slot_isolation got %h want not %h", out, TCT[0]); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] out; logic cen, err, seen; int lat;
    issue(ECB_ENCRYPT_128, 0, '0, PT, err, cen);
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({bus.busy, bus.en_o, bus.core_en} !== 3'b0) begin
      errors++; $display("FAIL midreset_flags got %b want 000", {bus.busy, bus.en_o, bus.core_en});
    end
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin step(); if (bus.en_o) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL stray_done got en_o=%b want 0", seen); end
    issue(ECB_ENCRYPT_128, 0, '0, PT, err, cen);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL slot0_cleared got err=%b want 1", err); end
    issue(ECB_ENCRYPT_128, 1, '0, PT, err, cen);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL slot1_cleared got err=%b want 1", err); end
    op(SET_KEY_128, 0, K1, '0, out, cen, lat);
    op(CTR_128, 0, '0, '0, out, cen, lat);
    checks++;
    if (last_core_in !== 128'h0 || out !== K1) begin
      errors++; $display("FAIL iv_cleared got in=%h out=%h want 0 %h", last_core_in, out, K1);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.aes_cmd = '0; bus.aes_key_slot = '0;
    bus.aes_key = '0; bus.aes_in_blk = '0;
    test_reset();
    test_ecb();
    test_cbc();
    test_ctr();
    test_wrap();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
